// File: rtl/chanels_averager_rr.sv
// chanels_averager_rr: per-channel block averager with a round-robin output.
// Tagged amplitude/phase samples are summed per channel in blocks of
// 2**AVG_LOG2 samples. Each finished mean waits in a per-channel result slot
// until the arbiter moves it into a one-entry valid/ready output register.
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   i_vld, i_addres     sample strobe and channel tag (tags >= CHANELS ignored)
//   i_ac, i_ph          unsigned amplitude, signed phase
//   i_flush             clears accumulation, pending and overrun state
//   o_vld, o_rdy        output handshake
//   o_addres, o_ac/o_ph channel and mean of the presented result
//   o_overrun           sticky per-channel "result overwritten" flags
// Build option: define CHANEL_AVG_ROUND_EN to round half-up before the shift;
// otherwise the mean is truncated (floor for phase).
module chanels_averager_rr #(
  parameter int CHANELS  = 4,
  parameter int DATA_W   = 32,
  parameter int AVG_LOG2 = 2,
  localparam int AW = (CHANELS > 1) ? $clog2(CHANELS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_vld,
  input  logic [AW-1:0]     i_addres,
  input  logic [DATA_W-1:0] i_ac,
  input  logic [DATA_W-1:0] i_ph,
  input  logic              i_flush,
  output logic              o_vld,
  input  logic              o_rdy,
  output logic [AW-1:0]     o_addres,
  output logic [DATA_W-1:0] o_ac,
  output logic [DATA_W-1:0] o_ph,
  output logic [CHANELS-1:0] o_overrun
);

  localparam int SW = DATA_W + AVG_LOG2;
  localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);
  localparam logic [AW:0] CH_LIM = (AW + 1)'(CHANELS);

`ifdef CHANEL_AVG_ROUND_EN
  localparam int RND = (1 << AVG_LOG2) / 2;
`else
  localparam int RND = 0;
`endif

  localparam logic        [SW-1:0] RND_AC = SW'(RND);
  localparam logic signed [SW-1:0] RND_PH = SW'(RND);

  logic        [SW-1:0]     acc_ac_q [CHANELS];
  logic        [SW-1:0]     acc_ac_d [CHANELS];
  logic signed [SW-1:0]     acc_ph_q [CHANELS];
  logic signed [SW-1:0]     acc_ph_d [CHANELS];
  logic        [CW-1:0]     cnt_q    [CHANELS];
  logic        [CW-1:0]     cnt_d    [CHANELS];
  logic        [DATA_W-1:0] res_ac_q [CHANELS];
  logic        [DATA_W-1:0] res_ac_d [CHANELS];
  logic        [DATA_W-1:0] res_ph_q [CHANELS];
  logic        [DATA_W-1:0] res_ph_d [CHANELS];
  logic [CHANELS-1:0] pend_q, pend_d;
  logic [CHANELS-1:0] ovr_q, ovr_d;

  logic              vld_q, vld_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0] ac_q, ac_d;
  logic [DATA_W-1:0] ph_q, ph_d;
  // Last granted channel; the search starts one past it.
  logic [AW-1:0]     rr_q, rr_d;

  logic              take;
  logic              cand;
  logic [AW-1:0]     cand_idx;
  logic              load;
  logic              gnt_c;
  int                j;
  logic        [SW-1:0] sum_ac, rnd_ac;
  logic signed [SW-1:0] sum_ph, rnd_ph;

  always_comb begin
    acc_ac_d = acc_ac_q;
    acc_ph_d = acc_ph_q;
    cnt_d    = cnt_q;
    res_ac_d = res_ac_q;
    res_ph_d = res_ph_q;
    pend_d   = pend_q;
    ovr_d    = ovr_q;
    vld_d    = vld_q;
    addr_d   = addr_q;
    ac_d     = ac_q;
    ph_d     = ph_q;
    rr_d     = rr_q;
    gnt_c    = 1'b0;
    sum_ac   = '0;
    sum_ph   = '0;
    rnd_ac   = '0;
    rnd_ph   = '0;
    j        = 0;

    take = i_vld & ~i_flush & ({1'b0, i_addres} < CH_LIM);

    cand     = 1'b0;
    cand_idx = '0;
    for (int i = 1; i <= CHANELS; i++) begin
      j = int'(rr_q) + i;
      if (j >= CHANELS) j = j - CHANELS;
      if (!cand && pend_q[j]) begin
        cand     = 1'b1;
        cand_idx = AW'(j);
      end
    end

    // Flush leaves the output register alone, so no new grant that cycle.
    load = cand & ~i_flush & (~vld_q | o_rdy);

    for (int c = 0; c < CHANELS; c++) begin
      sum_ac = acc_ac_q[c] + SW'(i_ac);
      sum_ph = acc_ph_q[c] + SW'(signed'(i_ph));
      gnt_c  = load && (cand_idx == AW'(c));
      if (gnt_c) pend_d[c] = 1'b0;
      if (take && (i_addres == AW'(c))) begin
        if (cnt_q[c] == CNT_LAST) begin
          rnd_ac = sum_ac + RND_AC;
          rnd_ph = sum_ph + RND_PH;
          res_ac_d[c] = DATA_W'(rnd_ac >> AVG_LOG2);
          res_ph_d[c] = DATA_W'(rnd_ph >>> AVG_LOG2);
          acc_ac_d[c] = '0;
          acc_ph_d[c] = '0;
          cnt_d[c]    = '0;
          // A grant this cycle takes the old result, so nothing is lost.
          if (pend_q[c] && !gnt_c) ovr_d[c] = 1'b1;
          pend_d[c] = 1'b1;
        end else begin
          acc_ac_d[c] = sum_ac;
          acc_ph_d[c] = sum_ph;
          cnt_d[c]    = cnt_q[c] + CW'(1);
        end
      end
    end

    if (i_flush) begin
      for (int c = 0; c < CHANELS; c++) begin
        acc_ac_d[c] = '0;
        acc_ph_d[c] = '0;
        cnt_d[c]    = '0;
      end
      pend_d = '0;
      ovr_d  = '0;
    end

    if (load) begin
      vld_d  = 1'b1;
      addr_d = cand_idx;
      ac_d   = res_ac_q[cand_idx];
      ph_d   = res_ph_q[cand_idx];
      rr_d   = cand_idx;
    end else if (vld_q && o_rdy) begin
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CHANELS; c++) begin
        acc_ac_q[c] <= '0;
        acc_ph_q[c] <= '0;
        cnt_q[c]    <= '0;
        res_ac_q[c] <= '0;
        res_ph_q[c] <= '0;
      end
      pend_q <= '0;
      ovr_q  <= '0;
      vld_q  <= 1'b0;
      addr_q <= '0;
      ac_q   <= '0;
      ph_q   <= '0;
      rr_q   <= AW'(CHANELS - 1);
    end else begin
      acc_ac_q <= acc_ac_d;
      acc_ph_q <= acc_ph_d;
      cnt_q    <= cnt_d;
      res_ac_q <= res_ac_d;
      res_ph_q <= res_ph_d;
      pend_q   <= pend_d;
      ovr_q    <= ovr_d;
      vld_q    <= vld_d;
      addr_q   <= addr_d;
      ac_q     <= ac_d;
      ph_q     <= ph_d;
      rr_q     <= rr_d;
    end
  end

  assign o_vld     = vld_q;
  assign o_addres  = addr_q;
  assign o_ac      = ac_q;
  assign o_ph      = ph_q;
  assign o_overrun = ovr_q;

endmodule

// File: tb/tb_chanels_averager_rr.sv
// Bench for chanels_averager_rr: directed scenarios plus a random stream
// compared against a per-channel block-mean model.
module tb_chanels_averager_rr;

`ifdef CHANEL_AVG_ROUND_EN
  localparam longint RND = 2;
  localparam logic [31:0] EXP_AC2 = 26;
`else
  localparam longint RND = 0;
  localparam logic [31:0] EXP_AC2 = 25;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_vld = 1'b0;
  logic [1:0]  i_addres = '0;
  logic [31:0] i_ac = '0;
  logic [31:0] i_ph = '0;
  logic        i_flush = 1'b0;
  logic        o_rdy = 1'b1;
  logic        o_vld;
  logic [1:0]  o_addres;
  logic [31:0] o_ac, o_ph;
  logic [3:0]  o_overrun;
  logic        u3_vld;
  logic [1:0]  u3_addr;
  logic [31:0] u3_ac, u3_ph;
  logic [2:0]  u3_ovr;

  chanels_averager_rr #(.CHANELS(4), .DATA_W(32), .AVG_LOG2(2)) u_dut (
    .clk(clk), .rst(rst), .i_vld(i_vld), .i_addres(i_addres),
    .i_ac(i_ac), .i_ph(i_ph), .i_flush(i_flush),
    .o_vld(o_vld), .o_rdy(o_rdy), .o_addres(o_addres),
    .o_ac(o_ac), .o_ph(o_ph), .o_overrun(o_overrun)
  );

  chanels_averager_rr #(.CHANELS(3), .DATA_W(32), .AVG_LOG2(2)) u_dut3 (
    .clk(clk), .rst(rst), .i_vld(i_vld), .i_addres(i_addres),
    .i_ac(i_ac), .i_ph(i_ph), .i_flush(i_flush),
    .o_vld(u3_vld), .o_rdy(o_rdy), .o_addres(u3_addr),
    .o_ac(u3_ac), .o_ph(u3_ph), .o_overrun(u3_ovr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [1:0]  ch;
    logic [31:0] ac;
    logic [31:0] ph;
  } exp_t;

  longint      sa [4];
  longint      sp [4];
  int          n  [4];
  logic [31:0] last_ac, last_ph;
  exp_t        q [$];
  int          ncyc = 0;
  bit          mon = 0;
  int          nchk = 0;
  int          npass = 0;
  int          nfail = 0;
  logic [31:0] e0a, e0p, e2a, e2p, e3a, e3p;

  function automatic logic [31:0] avg_ac(input longint s);
    return 32'((s + RND) / 4);
  endfunction

  function automatic logic [31:0] avg_ph(input longint s);
    longint t;
    longint r;
    t = s + RND;
    r = t / 4;
    if (t < 0 && (t % 4) != 0) r = r - 1;
    return 32'(r);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < 4; c++) begin
      sa[c] = 0;
      sp[c] = 0;
      n[c]  = 0;
    end
  endtask

  task automatic cyc(input logic v, input logic [1:0] a,
                     input logic [31:0] ac, input logic [31:0] ph,
                     input logic fl);
    exp_t e;
    i_vld = v;
    i_addres = a;
    i_ac = ac;
    i_ph = ph;
    i_flush = fl;
    @(posedge clk);
    ncyc++;
    if (fl) model_clear();
    else if (v) begin
      sa[a] += longint'(ac);
      sp[a] += longint'($signed(ph));
      n[a]++;
      if (n[a] == 4) begin
        last_ac = avg_ac(sa[a]);
        last_ph = avg_ph(sp[a]);
        sa[a] = 0;
        sp[a] = 0;
        n[a] = 0;
        if (mon) begin
          e.due = ncyc + 1;
          e.ch = a;
          e.ac = last_ac;
          e.ph = last_ph;
          q.push_back(e);
        end
      end
    end
    #1;
    i_vld = 1'b0;
    i_flush = 1'b0;
    if (mon) begin
      if (q.size() > 0 && q[0].due == ncyc) begin
        chk("sb_vld", 32'(o_vld), 32'd1);
        chk("sb_addr", 32'(o_addres), 32'(q[0].ch));
        chk("sb_ac", o_ac, q[0].ac);
        chk("sb_ph", o_ph, q[0].ph);
        q.delete(0);
      end else begin
        chk("sb_idle", 32'(o_vld), 32'd0);
      end
    end
  endtask

  task automatic idle();
    cyc(1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_vld = 1'b0;
    i_flush = 1'b0;
    #2;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    q.delete();
  endtask

  initial begin
    model_clear();
    do_reset();
    chk("rst_vld", 32'(o_vld), 32'd0);
    chk("rst_addr", 32'(o_addres), 32'd0);
    chk("rst_ac", o_ac, 32'd0);
    chk("rst_ph", o_ph, 32'd0);
    chk("rst_ovr", 32'(o_overrun), 32'd0);

    // basic average on ch1
    o_rdy = 1'b1;
    cyc(1, 1, 10, -1, 0);
    cyc(1, 1, 20, -2, 0);
    cyc(1, 1, 30, -4, 0);
    cyc(1, 1, 40, -5, 0);
    chk("basic_t1_vld", 32'(o_vld), 32'd0);
    idle();
    chk("basic_vld", 32'(o_vld), 32'd1);
    chk("basic_addr", 32'(o_addres), 32'd1);
    chk("basic_ac", o_ac, 32'd25);
    chk("basic_ph", o_ph, -32'sd3);
    idle();
    chk("basic_done", 32'(o_vld), 32'd0);
    cyc(1, 1, 10, 0, 0);
    cyc(1, 1, 20, 0, 0);
    cyc(1, 1, 30, 0, 0);
    cyc(1, 1, 42, 0, 0);
    idle();
    chk("basic2_vld", 32'(o_vld), 32'd1);
    chk("basic2_ac", o_ac, EXP_AC2);
    idle();

    // round-robin: ch0, ch2, ch3 finish back to back under backpressure
    o_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc(1, 0, $urandom, $urandom, 0);
      cyc(1, 2, $urandom, $urandom, 0);
      cyc(1, 3, $urandom, $urandom, 0);
    end
    cyc(1, 0, $urandom, $urandom, 0);
    e0a = last_ac; e0p = last_ph;
    cyc(1, 2, $urandom, $urandom, 0);
    e2a = last_ac; e2p = last_ph;
    cyc(1, 3, $urandom, $urandom, 0);
    e3a = last_ac; e3p = last_ph;
    idle();
    o_rdy = 1'b1;
    chk("rr0_vld", 32'(o_vld), 32'd1);
    chk("rr0_addr", 32'(o_addres), 32'd0);
    chk("rr0_ac", o_ac, e0a);
    chk("rr0_ph", o_ph, e0p);
    idle();
    chk("rr2_vld", 32'(o_vld), 32'd1);
    chk("rr2_addr", 32'(o_addres), 32'd2);
    chk("rr2_ac", o_ac, e2a);
    chk("rr2_ph", o_ph, e2p);
    idle();
    chk("rr3_vld", 32'(o_vld), 32'd1);
    chk("rr3_addr", 32'(o_addres), 32'd3);
    chk("rr3_ac", o_ac, e3a);
    chk("rr3_ph", o_ph, e3p);
    idle();
    chk("rr_done", 32'(o_vld), 32'd0);
    chk("rr_ovr", 32'(o_overrun), 32'd0);

    // backpressure and overrun on ch2
    o_rdy = 1'b0;
    for (int k = 0; k < 4; k++) cyc(1, 2, 8, 0, 0);
    for (int k = 0; k < 4; k++) begin
      cyc(1, 2, 12, 0, 0);
      chk("bp_vld", 32'(o_vld), 32'd1);
      chk("bp_ac_a", o_ac, 32'd8);
    end
    for (int k = 0; k < 4; k++) begin
      cyc(1, 2, 16, 0, 0);
      chk("bp_ac_b", o_ac, 32'd8);
    end
    idle();
    chk("bp_ac_c", o_ac, 32'd8);
    chk("bp_ovr", 32'(o_overrun), 32'h4);
    o_rdy = 1'b1;
    idle();
    chk("bp_next_vld", 32'(o_vld), 32'd1);
    chk("bp_next_addr", 32'(o_addres), 32'd2);
    chk("bp_next_ac", o_ac, 32'd16);
    idle();
    chk("bp_drained", 32'(o_vld), 32'd0);
    chk("bp_ovr_sticky", 32'(o_overrun), 32'h4);

    // flush discards a partial block and clears overrun
    cyc(1, 0, 100, 100, 0);
    cyc(1, 0, 100, 100, 0);
    cyc(1, 0, 100, 100, 1);
    chk("fl_ovr", 32'(o_overrun), 32'd0);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 0, 8, 8, 0);
      chk("fl_early", 32'(o_vld), 32'd0);
    end
    cyc(1, 0, 8, 8, 0);
    idle();
    chk("fl_vld", 32'(o_vld), 32'd1);
    chk("fl_ac", o_ac, 32'd8);
    chk("fl_ph", o_ph, 32'd8);
    idle();
    chk("fl_single", 32'(o_vld), 32'd0);

    // asynchronous reset mid-operation
    o_rdy = 1'b0;
    for (int k = 0; k < 4; k++) cyc(1, 3, 7, 7, 0);
    idle();
    chk("mr_pre_vld", 32'(o_vld), 32'd1);
    cyc(1, 1, 50, 0, 0);
    cyc(1, 1, 50, 0, 0);
    rst = 1'b1;
    #1;
    chk("mr_vld", 32'(o_vld), 32'd0);
    chk("mr_ac", o_ac, 32'd0);
    chk("mr_ph", o_ph, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    o_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("mr_early", 32'(o_vld), 32'd0);
      cyc(1, 1, 5, -5, 0);
    end
    idle();
    chk("mr_res_vld", 32'(o_vld), 32'd1);
    chk("mr_res_addr", 32'(o_addres), 32'd1);
    chk("mr_res_ac", o_ac, 32'd5);
    chk("mr_res_ph", o_ph, -32'sd5);

    // out-of-range tag on the 3-channel instance
    do_reset();
    o_rdy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc(1, 3, $urandom, $urandom, 0);
      chk("oor_vld", 32'(u3_vld), 32'd0);
    end
    chk("oor_ovr", 32'(u3_ovr), 32'd0);
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < 4; k++) cyc(1, 2'(c), $urandom, $urandom, 0);
      idle();
      chk("oor_res_vld", 32'(u3_vld), 32'd1);
      chk("oor_res_addr", 32'(u3_addr), 32'(c));
      chk("oor_res_ac", u3_ac, last_ac);
      chk("oor_res_ph", u3_ph, last_ph);
    end

    // random stream against the block-mean scoreboard
    do_reset();
    o_rdy = 1'b1;
    mon = 1;
    for (int k = 0; k < 300; k++) begin
      cyc($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
          $urandom, $urandom, 1'b0);
    end
    for (int k = 0; k < 4; k++) idle();
    chk("sb_empty", 32'(q.size()), 32'd0);
    mon = 0;

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
